// File: rtl/mips_pkg.sv
// mips_pkg
//    Shared encodings for the five-stage MIPS hazard logic: opcode and
//    funct values of the decoded instruction subset, the bgezal rt code,
//    forwarding select encodings and the shadow-stage record that tracks
//    each in-flight instruction's destination, remaining Tnew and MDU use.
package mips_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] FN_JR     = 6'b001000;
   localparam logic [5:0] FN_MFHI   = 6'b010000;
   localparam logic [5:0] FN_MTHI   = 6'b010001;
   localparam logic [5:0] FN_MFLO   = 6'b010010;
   localparam logic [5:0] FN_MTLO   = 6'b010011;
   localparam logic [5:0] FN_MULT   = 6'b011000;
   localparam logic [5:0] FN_DIV    = 6'b011010;
   localparam logic [5:0] FN_ADD    = 6'b100000;
   localparam logic [5:0] FN_SUB    = 6'b100010;

   // REGIMM rt field selecting bgezal
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   // Link register written by jal/bgezal
   localparam logic [4:0] REG_RA    = 5'd31;

   // Operand source selects
   typedef enum logic [1:0] {
      FWD_RF = 2'd0,   // register file / pipeline register
      FWD_E  = 2'd1,
      FWD_M  = 2'd2,
      FWD_W  = 2'd3
   } fwd_sel_e;

   // Shadow pipeline stage record
   typedef struct packed {
      logic [4:0] dst;
      logic [1:0] tnew;
      logic       is_md;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   // Tnew one stage later, saturating at zero
   function automatic logic [1:0] tnew_step(input logic [1:0] tnew);
      return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
   endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// mdu_busy_counter
//    Loadable down-counter modelling the multiply/divide unit busy window.
//    A load takes priority; otherwise the count decrements until zero.
// Ports:
//    clk_i        core clock
//    rst_ni       asynchronous active-low reset, clears the count
//    load_i       load load_val_i at the next rising edge
//    load_val_i   initial busy length
//    busy_o       count is non-zero
module mdu_busy_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             busy_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//    Stall and forwarding controller for the five-stage MIPS pipeline.
//    Decodes the instruction in D into per-operand Tuse and destination
//    Tnew, keeps a shadow E/M/W pipeline of destinations, and compares the
//    two to produce the stall and operand-forwarding selects. Also tracks
//    the multiply/divide unit busy window.
// Ports:
//    clk_i                  core clock
//    rst_ni                 asynchronous active-low reset
//    instr_d_i              instruction in D
//    stall_o                freeze PC and F/D, bubble into E
//    fwd_rs_d_o/fwd_rt_d_o  D operand source (0 RF, 1 E, 2 M, 3 W)
//    fwd_rs_e_o/fwd_rt_e_o  E operand source (0 pipe reg, 2 M, 3 W)
//    fwd_rt_m_o             M store data source (0 pipe reg, 1 W)
//    mdu_start_e_o          mult/div is in E this cycle
//    mdu_busy_o             MDU busy window active
module hazard_unit
   import mips_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] instr_d_i,
   output logic        stall_o,
   output logic [1:0]  fwd_rs_d_o,
   output logic [1:0]  fwd_rt_d_o,
   output logic [1:0]  fwd_rs_e_o,
   output logic [1:0]  fwd_rt_e_o,
   output logic        fwd_rt_m_o,
   output logic        mdu_start_e_o,
   output logic        mdu_busy_o
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   // ---------------------------------------------------------------
   // Decode of the instruction in D
   // ---------------------------------------------------------------
   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;

   assign op    = instr_d_i[31:26];
   assign rs    = instr_d_i[25:21];
   assign rt    = instr_d_i[20:16];
   assign rd    = instr_d_i[15:11];
   assign funct = instr_d_i[5:0];

   // Shamt and the low immediate bits never affect hazards.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr_d_i[10:6];

   logic       use_rs;
   logic       use_rt;
   logic [1:0] tuse_rs;
   logic [1:0] tuse_rt;
   logic [4:0] dec_dst;
   logic [1:0] dec_tnew;
   logic       dec_md;      // mult/div: starts the MDU
   logic       dec_div;
   logic       dec_mdu_op;  // any instruction that needs the MDU idle

   always_comb begin
      use_rs     = 1'b0;
      use_rt     = 1'b0;
      tuse_rs    = 2'd0;
      tuse_rt    = 2'd0;
      dec_dst    = 5'd0;
      dec_tnew   = 2'd0;
      dec_md     = 1'b0;
      dec_div    = 1'b0;
      dec_mdu_op = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB: begin
                  use_rs   = 1'b1;
                  use_rt   = 1'b1;
                  tuse_rs  = 2'd1;
                  tuse_rt  = 2'd1;
                  dec_dst  = rd;
                  dec_tnew = 2'd1;
               end
               FN_JR: begin
                  use_rs  = 1'b1;
                  tuse_rs = 2'd0;
               end
               FN_MULT, FN_DIV: begin
                  use_rs     = 1'b1;
                  use_rt     = 1'b1;
                  tuse_rs    = 2'd1;
                  tuse_rt    = 2'd1;
                  dec_md     = 1'b1;
                  dec_div    = (funct == FN_DIV);
                  dec_mdu_op = 1'b1;
               end
               FN_MFHI, FN_MFLO: begin
                  dec_dst    = rd;
                  dec_tnew   = 2'd1;
                  dec_mdu_op = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  use_rs     = 1'b1;
                  tuse_rs    = 2'd1;
                  dec_mdu_op = 1'b1;
               end
               default: ;
            endcase
         end
         OP_REGIMM: begin
            if (rt == RT_BGEZAL) begin
               use_rs   = 1'b1;
               tuse_rs  = 2'd0;
               dec_dst  = REG_RA;
               dec_tnew = 2'd0;
            end
         end
         OP_JAL: begin
            dec_dst  = REG_RA;
            dec_tnew = 2'd0;
         end
         OP_BEQ: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd0;
            tuse_rt = 2'd0;
         end
         OP_ORI: begin
            use_rs   = 1'b1;
            tuse_rs  = 2'd1;
            dec_dst  = rt;
            dec_tnew = 2'd1;
         end
         OP_LUI: begin
            dec_dst  = rt;
            dec_tnew = 2'd1;
         end
         OP_LW: begin
            use_rs   = 1'b1;
            tuse_rs  = 2'd1;
            dec_dst  = rt;
            dec_tnew = 2'd2;
         end
         OP_SW: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd2;
         end
         default: ;  // OP_J and unknown encodings: no uses, no destination
      endcase
   end

   // Sources are masked to $0 when unused so that no comparator, in any
   // stage, can hit on a field that is not really a register operand.
   logic [4:0] src_d [2];
   logic [1:0] tuse_d [2];

   assign src_d[0]  = use_rs ? rs : 5'd0;
   assign src_d[1]  = use_rt ? rt : 5'd0;
   assign tuse_d[0] = tuse_rs;
   assign tuse_d[1] = tuse_rt;

   // ---------------------------------------------------------------
   // Shadow pipeline
   // ---------------------------------------------------------------
   stage_t     e_q, e_d;
   stage_t     m_q, m_d;
   stage_t     w_q, w_d;
   logic       div_e_q, div_e_d;
   logic [4:0] rs_e_q, rs_e_d;
   logic [4:0] rt_e_q, rt_e_d;
   logic [4:0] rt_m_q, rt_m_d;

   logic stall;

   always_comb begin
      e_d     = STAGE_BUBBLE;
      div_e_d = 1'b0;
      rs_e_d  = 5'd0;
      rt_e_d  = 5'd0;
      if (!stall) begin
         e_d.dst   = dec_dst;
         e_d.tnew  = dec_tnew;
         e_d.is_md = dec_md;
         div_e_d   = dec_div;
         rs_e_d    = src_d[0];
         rt_e_d    = src_d[1];
      end
      m_d      = e_q;
      m_d.tnew = tnew_step(e_q.tnew);
      rt_m_d   = rt_e_q;
      w_d      = m_q;
      w_d.tnew = 2'd0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e_q     <= STAGE_BUBBLE;
         m_q     <= STAGE_BUBBLE;
         w_q     <= STAGE_BUBBLE;
         div_e_q <= 1'b0;
         rs_e_q  <= 5'd0;
         rt_e_q  <= 5'd0;
         rt_m_q  <= 5'd0;
      end else begin
         e_q     <= e_d;
         m_q     <= m_d;
         w_q     <= w_d;
         div_e_q <= div_e_d;
         rs_e_q  <= rs_e_d;
         rt_e_q  <= rt_e_d;
         rt_m_q  <= rt_m_d;
      end
   end

   // ---------------------------------------------------------------
   // MDU busy window
   // ---------------------------------------------------------------
   logic mdu_busy;

   assign mdu_start_e_o = e_q.is_md;

   mdu_busy_counter #(
      .CNT_W (CNT_W)
   ) u_mdu_busy_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (e_q.is_md),
      .load_val_i (div_e_q ? DIV_LOAD : MULT_LOAD),
      .busy_o     (mdu_busy)
   );

   assign mdu_busy_o = mdu_busy;

   // ---------------------------------------------------------------
   // Per-operand hazard detection and forwarding (0 = rs, 1 = rt)
   // ---------------------------------------------------------------
   logic [1:0] reg_hazard;
   logic [1:0] fwd_d [2];
   logic [1:0] fwd_e [2];
   logic [4:0] src_e [2];

   assign src_e[0] = rs_e_q;
   assign src_e[1] = rt_e_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      // A producer still needing more cycles than the consumer can wait.
      assign reg_hazard[gi] = (src_d[gi] != 5'd0) &&
         (((e_q.dst == src_d[gi]) && (e_q.tnew > tuse_d[gi])) ||
          ((m_q.dst == src_d[gi]) && (m_q.tnew > tuse_d[gi])));

      always_comb begin
         fwd_d[gi] = FWD_RF;
         if (src_d[gi] != 5'd0) begin
            if ((e_q.dst == src_d[gi]) && (e_q.tnew == 2'd0)) begin
               fwd_d[gi] = FWD_E;
            end else if ((m_q.dst == src_d[gi]) && (m_q.tnew == 2'd0)) begin
               fwd_d[gi] = FWD_M;
            end else if (w_q.dst == src_d[gi]) begin
               fwd_d[gi] = FWD_W;
            end
         end
      end

      always_comb begin
         fwd_e[gi] = FWD_RF;
         if (src_e[gi] != 5'd0) begin
            if ((m_q.dst == src_e[gi]) && (m_q.tnew == 2'd0)) begin
               fwd_e[gi] = FWD_M;
            end else if (w_q.dst == src_e[gi]) begin
               fwd_e[gi] = FWD_W;
            end
         end
      end
   end

   assign fwd_rs_d_o = fwd_d[0];
   assign fwd_rt_d_o = fwd_d[1];
   assign fwd_rs_e_o = fwd_e[0];
   assign fwd_rt_e_o = fwd_e[1];
   assign fwd_rt_m_o = (rt_m_q != 5'd0) && (w_q.dst == rt_m_q);

   // An MDU access must wait while an operation is in E or still running.
   assign stall   = (|reg_hazard) || (dec_mdu_op && (mdu_busy || e_q.is_md));
   assign stall_o = stall;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//    Directed-vector bench for hazard_unit. The bench plays the role of
//    the F/D register: it holds the D instruction steady while stall is
//    high. Expected values are hand-derived from the pipeline timing.
module tb_hazard_unit;

   logic        clk_i;
   logic        rst_ni;
   logic [31:0] instr_d_i;
   logic        stall_o;
   logic [1:0]  fwd_rs_d_o;
   logic [1:0]  fwd_rt_d_o;
   logic [1:0]  fwd_rs_e_o;
   logic [1:0]  fwd_rt_e_o;
   logic        fwd_rt_m_o;
   logic        mdu_start_e_o;
   logic        mdu_busy_o;

   int checks_cnt;
   int fail_cnt;

   hazard_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .instr_d_i     (instr_d_i),
      .stall_o       (stall_o),
      .fwd_rs_d_o    (fwd_rs_d_o),
      .fwd_rt_d_o    (fwd_rt_d_o),
      .fwd_rs_e_o    (fwd_rs_e_o),
      .fwd_rt_e_o    (fwd_rt_e_o),
      .fwd_rt_m_o    (fwd_rt_m_o),
      .mdu_start_e_o (mdu_start_e_o),
      .mdu_busy_o    (mdu_busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Instruction encoders
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; leave the sample point 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input string txn, input logic [31:0] instr);
      instr_d_i = instr;
      #1;
      $display("txn %-14s instr=%08h stall=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d fwd_m=%0b start=%0b busy=%0b",
               txn, instr, stall_o, fwd_rs_d_o, fwd_rt_d_o, fwd_rs_e_o, fwd_rt_e_o,
               fwd_rt_m_o, mdu_start_e_o, mdu_busy_o);
   endtask

   task automatic flush();
      instr_d_i = 32'd0;
      repeat (4) tick();
   endtask

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [31:0] JAL_0  = 32'h0C00_0000;

   initial begin
      int stall_n;
      int start_n;
      int busy_n;
      int guard;

      checks_cnt = 0;
      fail_cnt   = 0;
      rst_ni     = 1'b0;
      instr_d_i  = enc_i(OP_LW, 5'd0, 5'd1, 16'd0);

      // Reset state must hold before any clock edge.
      #1;
      check_val("rst_stall", stall_o, 0);
      check_val("rst_fwd_d", {fwd_rs_d_o, fwd_rt_d_o}, 0);
      check_val("rst_fwd_em", {fwd_rs_e_o, fwd_rt_e_o, fwd_rt_m_o}, 0);
      check_val("rst_mdu", {mdu_start_e_o, mdu_busy_o}, 0);
      repeat (2) tick();
      rst_ni    = 1'b1;
      instr_d_i = 32'd0;
      tick();

      // lw $1 then add $2,$1,$1: one-cycle stall, then W->E forwarding.
      drive("lw1", enc_i(OP_LW, 5'd0, 5'd1, 16'd0));
      check_val("lw_issue_stall", stall_o, 0);
      tick();
      drive("add_dep", enc_r(5'd1, 5'd1, 5'd2, FN_ADD));
      check_val("lw_add_stall_c1", stall_o, 1);
      tick();
      drive("add_dep", enc_r(5'd1, 5'd1, 5'd2, FN_ADD));
      check_val("lw_add_stall_c2", stall_o, 0);
      tick();
      drive("nop", 32'd0);
      check_val("lw_add_fwd_rs_e", fwd_rs_e_o, 3);
      check_val("lw_add_fwd_rt_e", fwd_rt_e_o, 3);
      flush();

      // lw $1 then beq $1,$2: two-cycle stall, then W->D forwarding.
      drive("lw1", enc_i(OP_LW, 5'd0, 5'd1, 16'd0));
      tick();
      drive("beq_dep", enc_i(OP_BEQ, 5'd1, 5'd2, 16'd0));
      check_val("lw_beq_stall_c1", stall_o, 1);
      tick();
      drive("beq_dep", enc_i(OP_BEQ, 5'd1, 5'd2, 16'd0));
      check_val("lw_beq_stall_c2", stall_o, 1);
      tick();
      drive("beq_dep", enc_i(OP_BEQ, 5'd1, 5'd2, 16'd0));
      check_val("lw_beq_stall_c3", stall_o, 0);
      check_val("lw_beq_fwd_rs_d", fwd_rs_d_o, 3);
      check_val("lw_beq_fwd_rt_d", fwd_rt_d_o, 0);
      flush();

      // add $3 then beq $3,$0: one-cycle stall, then M->D forwarding.
      drive("add3", enc_r(5'd1, 5'd2, 5'd3, FN_ADD));
      tick();
      drive("beq3", enc_i(OP_BEQ, 5'd3, 5'd0, 16'd0));
      check_val("add_beq_stall_c1", stall_o, 1);
      tick();
      drive("beq3", enc_i(OP_BEQ, 5'd3, 5'd0, 16'd0));
      check_val("add_beq_stall_c2", stall_o, 0);
      check_val("add_beq_fwd_rs_d", fwd_rs_d_o, 2);
      flush();

      // ori $4; jal; jr $31: no stall, jr takes $31 from E.
      drive("ori4", enc_i(OP_ORI, 5'd0, 5'd4, 16'd5));
      check_val("ori_stall", stall_o, 0);
      tick();
      drive("jal", JAL_0);
      check_val("jal_stall", stall_o, 0);
      tick();
      drive("jr31", enc_r(5'd31, 5'd0, 5'd0, FN_JR));
      check_val("jr_stall", stall_o, 0);
      check_val("jr_fwd_rs_d", fwd_rs_d_o, 1);
      flush();

      // add $5 then sw $5: no stall; store data from M in E, then from W in M.
      drive("add5", enc_r(5'd1, 5'd2, 5'd5, FN_ADD));
      tick();
      drive("sw5", enc_i(OP_SW, 5'd0, 5'd5, 16'd0));
      check_val("add_sw_stall", stall_o, 0);
      tick();
      drive("nop", 32'd0);
      check_val("sw_fwd_rt_e", fwd_rt_e_o, 2);
      tick();
      check_val("sw_fwd_rt_m", fwd_rt_m_o, 1);
      flush();

      // add $0,$1,$1 then add $6,$0,$0: $0 never stalls or forwards.
      drive("add0", enc_r(5'd1, 5'd1, 5'd0, FN_ADD));
      tick();
      drive("use0", enc_r(5'd0, 5'd0, 5'd6, FN_ADD));
      check_val("zero_stall", stall_o, 0);
      check_val("zero_fwd_d", {fwd_rs_d_o, fwd_rt_d_o}, 0);
      tick();
      drive("nop", 32'd0);
      check_val("zero_fwd_e", {fwd_rs_e_o, fwd_rt_e_o}, 0);
      flush();

      // mult: start for one cycle, then busy for MULT_CYCLES=5 cycles.
      drive("mult", enc_r(5'd1, 5'd2, 5'd0, FN_MULT));
      tick();
      drive("nop", 32'd0);
      check_val("mult_start", mdu_start_e_o, 1);
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         busy_n += int'(mdu_busy_o);
      end
      check_val("mult_busy_cycles", busy_n, 5);
      flush();

      // div then mflo: 1 start + 10 busy cycles, stall for 11 cycles.
      drive("div", enc_r(5'd1, 5'd2, 5'd0, FN_DIV));
      check_val("div_issue_stall", stall_o, 0);
      tick();
      drive("mflo7", enc_r(5'd0, 5'd0, 5'd7, FN_MFLO));
      stall_n = 0;
      start_n = 0;
      busy_n  = 0;
      guard   = 0;
      while (stall_o && guard < 30) begin
         stall_n += 1;
         start_n += int'(mdu_start_e_o);
         busy_n  += int'(mdu_busy_o);
         guard   += 1;
         tick();
      end
      check_val("div_stall_cycles", stall_n, 11);
      check_val("div_start_cycles", start_n, 1);
      check_val("div_busy_cycles", busy_n, 10);
      check_val("div_idle_after", {mdu_busy_o, mdu_start_e_o}, 0);
      tick();
      // mflo now in E with Tnew 1: a branch on $7 must stall.
      drive("beq7", enc_i(OP_BEQ, 5'd7, 5'd0, 16'd0));
      check_val("mflo_in_e_stall", stall_o, 1);
      flush();

      // Reset asserted mid-countdown clears busy and stall immediately.
      drive("div", enc_r(5'd1, 5'd2, 5'd0, FN_DIV));
      tick();
      drive("mfhi8", enc_r(5'd0, 5'd0, 5'd8, FN_MFHI));
      tick();
      tick();
      check_val("mid_busy", mdu_busy_o, 1);
      check_val("mid_stall", stall_o, 1);
      rst_ni = 1'b0;
      #1;
      check_val("async_rst_busy", mdu_busy_o, 0);
      check_val("async_rst_stall", stall_o, 0);
      tick();
      rst_ni = 1'b1;
      drive("mfhi8", enc_r(5'd0, 5'd0, 5'd8, FN_MFHI));
      check_val("post_rst_stall", stall_o, 0);
      tick();
      drive("nop", 32'd0);
      check_val("post_rst_start", {mdu_start_e_o, mdu_busy_o}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: observed running, expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
